// File: rtl/note_hit_scorer.sv
// note_hit_scorer: turns raw fret switches and per-lane note-window events into
// a saturating score, a combo count, a multiplier and hit/miss strobes.
// Input path per lane: 2-flop sync -> debounce -> registered rising-edge detect.
module note_hit_scorer #(
    parameter int LANES           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HIT_POINTS      = 10,
    parameter int SCORE_MAX       = 999999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [LANES-1:0] switches,
    input  logic [LANES-1:0] note_enter,
    input  logic [LANES-1:0] note_exit,
    output logic [19:0]      score,
    output logic [7:0]       combo,
    output logic [2:0]       multiplier,
    output logic             hit_pulse,
    output logic             miss_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LANES + 1);

    logic [LANES-1:0] sync1, sync2;
    logic [LANES-1:0] stable, stable_q;
    logic [LANES-1:0] press_evt;
    logic [LANES-1:0] armed, armed_next;
    logic [LANES-1:0] hit_vec, miss_vec;
    logic [CW-1:0]    db_cnt [LANES];

    logic [HW-1:0] hit_cnt;
    logic [31:0]   score_sum;
    logic [19:0]   score_next;
    logic [8:0]    combo_sum;
    logic [7:0]    combo_next;
    logic [2:0]    mult_next;

    // Two-flop synchroniser for the asynchronous fret switches
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values
        // regardless of statement order; = here would chain sync1 into sync2.
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
        end
    end

    // Debounce: stable level follows the synced level after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: db_cnt is a per-lane array of counters built from flops, not a
        // RAM, so it is cleared in reset like any other state.
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < LANES; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising-edge detect on the debounced level, registered as press_evt
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_q  <= '0;
            press_evt <= '0;
        end else begin
            stable_q  <= stable;
            press_evt <= stable & ~stable_q;
        end
    end

    // Per-lane judgement in priority order: enter, press, exit
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        armed_next = armed;
        hit_vec    = '0;
        miss_vec   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (note_enter[i]) begin
                if (armed_next[i]) miss_vec[i] = 1'b1;
                else               armed_next[i] = 1'b1;
            end
            if (press_evt[i]) begin
                if (armed_next[i]) begin
                    hit_vec[i]    = 1'b1;
                    armed_next[i] = 1'b0;
                end else begin
                    miss_vec[i] = 1'b1;
                end
            end else if (note_exit[i] && armed_next[i]) begin
                miss_vec[i]   = 1'b1;
                armed_next[i] = 1'b0;
            end
        end
    end

    // Score, combo and multiplier update from this cycle's hit/miss totals
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LANES; i++) hit_cnt = hit_cnt + HW'(hit_vec[i]);

        score_sum  = 32'(score) + 32'(hit_cnt) * 32'(HIT_POINTS) * 32'(multiplier);
        score_next = (score_sum > 32'(SCORE_MAX)) ? 20'(SCORE_MAX) : score_sum[19:0];

        combo_sum = 9'(combo) + 9'(hit_cnt);
        if (|miss_vec)             combo_next = 8'd0;
        else if (combo_sum > 9'd255) combo_next = 8'd255;
        else                       combo_next = combo_sum[7:0];

        mult_next = (combo_next >= 8'd24) ? 3'd4 : 3'd1 + {1'b0, combo_next[4:3]};
    end

    // Registered outputs and armed flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed      <= '0;
            score      <= '0;
            combo      <= '0;
            multiplier <= 3'd1;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            armed      <= armed_next;
            score      <= score_next;
            combo      <= combo_next;
            multiplier <= mult_next;
            hit_pulse  <= |hit_vec;
            miss_pulse <= |miss_vec;
        end
    end

endmodule

// File: tb/tb_note_hit_scorer.sv
// Testbench for note_hit_scorer: directed scenarios plus randomized play,
// every cycle compared against a behavioural scoring model.
module tb_note_hit_scorer;

    localparam int LANES = 4;
    localparam int D     = 4;
    localparam int HP    = 10;
    localparam int SMAX  = 999999;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [LANES-1:0] switches = '0, note_enter = '0, note_exit = '0;
    logic [19:0]      score;
    logic [7:0]       combo;
    logic [2:0]       multiplier;
    logic             hit_pulse, miss_pulse;

    int total = 0;
    int bad   = 0;

    note_hit_scorer #(
        .LANES(LANES), .DEBOUNCE_CYCLES(D), .HIT_POINTS(HP), .SCORE_MAX(SMAX)
    ) dut (
        .clock(clock), .reset(reset), .switches(switches),
        .note_enter(note_enter), .note_exit(note_exit),
        .score(score), .combo(combo), .multiplier(multiplier),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_score, m_combo, m_mult;
    bit m_hit, m_miss;
    bit s1[LANES], s2[LANES], stab[LANES], stab_prev[LANES], press[LANES], arm[LANES];
    int hist[LANES];  // last D synced samples, newest in bit 0
    localparam int MASK = (1 << D) - 1;

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_mult = 1; m_hit = 0; m_miss = 0;
        for (int i = 0; i < LANES; i++) begin
            s1[i] = 0; s2[i] = 0; stab[i] = 0; stab_prev[i] = 0;
            press[i] = 0; arm[i] = 0; hist[i] = 0;
        end
    endtask

    task automatic model_step(input logic [LANES-1:0] sw, input logic [LANES-1:0] ne,
                              input logic [LANES-1:0] nx);
        int h = 0, mi = 0;
        for (int i = 0; i < LANES; i++) begin
            bit a = arm[i];
            if (ne[i]) begin
                if (a) mi++; else a = 1;
            end
            if (press[i]) begin
                if (a) begin h++; a = 0; end else mi++;
            end else if (nx[i] && a) begin
                mi++; a = 0;
            end
            arm[i] = a;
        end
        m_score = m_score + h * HP * m_mult;
        if (m_score > SMAX) m_score = SMAX;
        m_combo = (mi > 0) ? 0 : ((m_combo + h > 255) ? 255 : m_combo + h);
        m_mult  = (1 + m_combo / 8 > 4) ? 4 : 1 + m_combo / 8;
        m_hit   = (h > 0);
        m_miss  = (mi > 0);
        for (int i = 0; i < LANES; i++) begin
            press[i]     = stab[i] & ~stab_prev[i];
            stab_prev[i] = stab[i];
            hist[i]      = ((hist[i] << 1) | int'(s2[i])) & MASK;
            if (hist[i] == (stab[i] ? 0 : MASK)) stab[i] = ~stab[i];
            s2[i] = s1[i];
            s1[i] = sw[i];
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    bit saw_hit, saw_miss;
    task automatic tick(input logic [LANES-1:0] sw, input logic [LANES-1:0] ne,
                        input logic [LANES-1:0] nx);
        switches = sw; note_enter = ne; note_exit = nx;
        @(posedge clock);
        model_step(sw, ne, nx);
        @(negedge clock);
        check("score", score, m_score);
        check("combo", combo, m_combo);
        check("mult",  multiplier, m_mult);
        check("hit",   hit_pulse, m_hit);
        check("miss",  miss_pulse, m_miss);
        saw_hit  |= hit_pulse;
        saw_miss |= miss_pulse;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; switches = '0; note_enter = '0; note_exit = '0;
        #1;
        check("rst_score", score, 0);
        check("rst_combo", combo, 0);
        check("rst_mult",  multiplier, 1);
        check("rst_hit",   hit_pulse, 0);
        check("rst_miss",  miss_pulse, 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Press one lane cleanly (optionally arming a note first), then release
    task automatic press_lane(input int lane, input bit with_note);
        logic [LANES-1:0] m;
        m = '0; m[lane] = 1'b1;
        saw_hit = 0; saw_miss = 0;
        if (with_note) tick('0, m, '0);
        repeat (8) tick(m, '0, '0);
        repeat (7) tick('0, '0, '0);
    endtask

    initial begin
        int first;
        int budget;
        logic [LANES-1:0] sw_r, ne_r, nx_r;
        int hold[LANES];

        model_reset();
        do_reset();
        repeat (20) tick('0, '0, '0);
        check("idle_score", score, 0);
        check("idle_combo", combo, 0);
        check("idle_mult",  multiplier, 1);

        // Armed lane 0, clean press: hit lands D+4 cycles after the raw rise
        tick('0, 4'b0001, '0);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0001, '0, '0);
            if (hit_pulse && first == 0) first = k;
        end
        check("latency", first, D + 4);
        check("hit1_score", score, 10);
        check("hit1_combo", combo, 1);
        repeat (8) tick('0, '0, '0);

        // Wrong fret
        press_lane(3, 0);
        check("wrong_hit",   saw_hit, 0);
        check("wrong_miss",  saw_miss, 1);
        check("wrong_combo", combo, 0);
        check("wrong_score", score, 10);

        // Enter then exit on lane 2 without a press
        tick('0, 4'b0100, '0);
        tick('0, '0, '0);
        tick('0, '0, 4'b0100);
        check("exit_miss", miss_pulse, 1);
        tick('0, '0, 4'b0100);
        check("exit_disarmed", miss_pulse, 0);

        // Multiplier progression from a clean start
        do_reset();
        for (int n = 0; n < 8; n++) press_lane(0, 1);
        check("h8_score", score, 80);
        check("h8_mult",  multiplier, 2);
        press_lane(0, 1);
        check("h9_score", score, 100);
        for (int n = 0; n < 24; n++) press_lane(0, 1);
        check("h33_combo", combo, 33);
        check("h33_mult",  multiplier, 4);
        press_lane(0, 1);
        check("h34_mult",  multiplier, 4);

        // 3-cycle glitch on lane 1 with a note armed: nothing happens
        tick('0, 4'b0010, '0);
        saw_hit = 0; saw_miss = 0;
        repeat (3) tick(4'b0010, '0, '0);
        repeat (12) tick('0, '0, '0);
        check("glitch_hit",  saw_hit, 0);
        check("glitch_miss", saw_miss, 0);

        // Randomized play
        sw_r = '0;
        for (int i = 0; i < LANES; i++) hold[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < LANES; i++) begin
                if (hold[i] == 0) begin
                    sw_r[i] = ~sw_r[i];
                    hold[i] = $urandom_range(1, 12);
                end
                hold[i]--;
                ne_r[i] = ($urandom_range(0, 15) == 0);
                nx_r[i] = ($urandom_range(0, 15) == 0);
            end
            tick(sw_r, ne_r, nx_r);
        end
        repeat (10) tick('0, '0, '0);

        // Reset in the middle of a debounce: no late hit afterwards
        tick('0, 4'b0001, '0);
        repeat (4) tick(4'b0001, '0, '0);
        do_reset();
        saw_hit = 0; saw_miss = 0;
        repeat (15) tick('0, '0, '0);
        check("late_hit",  saw_hit, 0);
        check("late_miss", saw_miss, 0);

        // Fill towards saturation: 4-lane rounds, then single-lane rounds
        budget = 0;
        while (m_score < SMAX - 40 - 160 && budget < 7000) begin
            tick(4'b1111, 4'b1111, '0);
            repeat (3) tick(4'b1111, '0, '0);
            repeat (4) tick('0, '0, '0);
            budget++;
        end
        check("fill_budget", (budget < 7000), 1);
        budget = 0;
        while (m_score < SMAX - 39 && budget < 20) begin
            press_lane(0, 1);
            budget++;
        end
        check("near_max", (score > SMAX - 40) && (score < SMAX), 1);
        press_lane(0, 1);
        check("sat_hit",   saw_hit, 1);
        check("sat_score", score, SMAX);
        check("sat_combo", combo, 255);
        press_lane(1, 1);
        check("sat_hold",  score, SMAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
